fft_bitrev_reorder: RTL and testbench

Streaming output reorder buffer that sits after the last butterfly stage of the radix-2 FFT pipeline. It reads frames of N_POINTS complex samples, which arrive in bit-reversed index order. It emits each frame in natural index order, narrowed from VIRTUAL_DATA_WIDTH to DATA_WIDTH with saturation. Two frame banks in ping-pong sustain one sample per cycle.

---
 rtl/fft_pkg.sv | 60 ++++++
 rtl/fft_sdp_ram.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 177 +++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
//   bank_state_t : life cycle of one frame bank in the ping-pong buffer
//   bitrev       : reverses the low log2n bits of an index (log2n <= 16)
//   sat_narrow   : clamps a sign-extended value to a dw-bit signed range
//                  and reports whether clamping happened (dw <= 31)
package fft_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int BITREV_MAX_W = 16;
  localparam int SAT_CALC_W   = 32;

  typedef struct packed {
    logic [SAT_CALC_W-1:0] value;
    logic                  clamped;
  } sat_result_t;

  // Bits at and above log2n are returned as zero so callers can truncate.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] idx,
    input int                      log2n
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < log2n) r[i] = idx[log2n-1-i];
    end
    return r;
  endfunction

  // x must already be sign-extended to SAT_CALC_W bits. The low dw bits of
  // .value are the narrowed result.
  function automatic sat_result_t sat_narrow(
    input logic signed [SAT_CALC_W-1:0] x,
    input int                           dw
  );
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    sat_result_t res;
    max_v = (32'sd1 <<< (dw - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (dw - 1));
    if (x > max_v) begin
      res.value   = max_v;
      res.clamped = 1'b1;
    end else if (x < min_v) begin
      res.value   = min_v;
      res.clamped = 1'b1;
    end else begin
      res.value   = x;
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// Simple dual-port RAM holding both frame banks of the reorder buffer.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address (MSB selects the bank)
//   i_wdata : write data {real, imag}
//   i_raddr : read address (MSB selects the bank)
//   o_rdata : read data, combinational from i_raddr
module fft_sdp_ram
  import fft_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 36,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The output register in the parent provides the pipeline stage, so the
  // read path stays combinational here.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Streaming reorder buffer placed after the last radix-2 butterfly stage.
// Frames of N_POINTS complex samples arrive in bit-reversed order, are
// written to one of two banks at their natural address, and are read out
// in natural order while the other bank fills. Output parts are saturated
// from VIRTUAL_DATA_WIDTH down to DATA_WIDTH at the output register.
//   clk, rst                      : clock, synchronous active-high reset
//   enable                        : global advance; low freezes everything
//   in_valid/in_ready/in_real/imag: input stream (bit-reversed order)
//   out_valid/out_ready           : output handshake
//   out_real/out_imag             : narrowed, saturated sample
//   out_index/out_last/out_sat    : natural bin, last-of-frame, clamp flag
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter  int N_POINTS           = 8,
  parameter  int DATA_WIDTH         = 16,
  parameter  int VIRTUAL_DATA_WIDTH = 18,
  localparam int LOG2_N             = $clog2(N_POINTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [VIRTUAL_DATA_WIDTH-1:0] in_real,
  input  logic signed [VIRTUAL_DATA_WIDTH-1:0] in_imag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [DATA_WIDTH-1:0]         out_real,
  output logic signed [DATA_WIDTH-1:0]         out_imag,
  output logic [LOG2_N-1:0]                    out_index,
  output logic                                 out_last,
  output logic                                 out_sat
);

  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);
  localparam int                RAM_W    = 2 * VIRTUAL_DATA_WIDTH;

  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [LOG2_N-1:0]   r_wr_cnt;
  logic [LOG2_N-1:0]   r_rd_cnt;
  logic                r_out_valid;
  logic signed [DATA_WIDTH-1:0] r_out_real;
  logic signed [DATA_WIDTH-1:0] r_out_imag;
  logic [LOG2_N-1:0]   r_out_index;
  logic                r_out_last;
  logic                r_out_sat;

  bank_state_t         w_bank_state [2];
  logic                w_in_ready;
  logic                w_wr_fire;
  logic                w_load;
  logic [LOG2_N:0]     w_wr_addr;
  logic [LOG2_N:0]     w_rd_addr;
  logic [RAM_W-1:0]    w_rd_data;
  logic signed [VIRTUAL_DATA_WIDTH-1:0] w_rd_re;
  logic signed [VIRTUAL_DATA_WIDTH-1:0] w_rd_im;
  sat_result_t         w_sat_re;
  sat_result_t         w_sat_im;

  // ---------------------------------------------------------------------
  // Handshake decisions
  // ---------------------------------------------------------------------
  assign w_in_ready = enable &&
                      (w_bank_state[r_wr_bank] == EMPTY ||
                       w_bank_state[r_wr_bank] == FILLING);
  assign w_wr_fire  = in_valid && w_in_ready;

  // The write bank is always EMPTY/FILLING and the read bank FULL/DRAINING
  // when they act, so the two ports never touch the same bank together.
  assign w_load = enable && (!r_out_valid || out_ready) &&
                  (w_bank_state[r_rd_bank] == FULL ||
                   w_bank_state[r_rd_bank] == DRAINING);

  // ---------------------------------------------------------------------
  // Per-bank state machines
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bank_state_t r_state;
    bank_state_t w_next;

    always_comb begin
      w_next = r_state;
      if (w_wr_fire && (r_wr_bank == 1'(gi))) begin
        w_next = (r_wr_cnt == LAST_IDX) ? FULL : FILLING;
      end
      if (w_load && (r_rd_bank == 1'(gi))) begin
        w_next = (r_rd_cnt == LAST_IDX) ? EMPTY : DRAINING;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else     r_state <= w_next;
    end

    assign w_bank_state[gi] = r_state;
  end

  // ---------------------------------------------------------------------
  // Frame storage: the k-th arriving sample belongs at bin bitrev(k)
  // ---------------------------------------------------------------------
  assign w_wr_addr = {r_wr_bank, LOG2_N'(bitrev(BITREV_MAX_W'(r_wr_cnt), LOG2_N))};
  assign w_rd_addr = {r_rd_bank, r_rd_cnt};

  fft_sdp_ram #(
    .DEPTH (2 * N_POINTS),
    .WIDTH (RAM_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr (w_wr_addr),
    .i_wdata ({in_real, in_imag}),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign w_rd_re  = w_rd_data[RAM_W-1 -: VIRTUAL_DATA_WIDTH];
  assign w_rd_im  = w_rd_data[VIRTUAL_DATA_WIDTH-1:0];
  assign w_sat_re = sat_narrow(SAT_CALC_W'(w_rd_re), DATA_WIDTH);
  assign w_sat_im = sat_narrow(SAT_CALC_W'(w_rd_im), DATA_WIDTH);

  // ---------------------------------------------------------------------
  // Counters, bank pointers and output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
    end else if (enable) begin
      if (w_wr_fire) begin
        if (r_wr_cnt == LAST_IDX) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_real  <= DATA_WIDTH'(w_sat_re.value);
        r_out_imag  <= DATA_WIDTH'(w_sat_im.value);
        r_out_sat   <= w_sat_re.clamped || w_sat_im.clamped;
        r_out_index <= r_rd_cnt;
        r_out_last  <= (r_rd_cnt == LAST_IDX);
        if (r_rd_cnt == LAST_IDX) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Valid is masked while frozen; the held sample returns with enable.
  assign in_ready  = w_in_ready;
  assign out_valid = enable && r_out_valid;
  assign out_real  = r_out_real;
  assign out_imag  = r_out_imag;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder (N=8, 18 -> 16 bits).
module tb_fft_bitrev_reorder;

  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int VDW = 18;
  localparam int LN  = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [VDW-1:0] in_real;
  logic signed [VDW-1:0] in_imag;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [DW-1:0]  out_real;
  logic signed [DW-1:0]  out_imag;
  logic [LN-1:0]         out_index;
  logic                  out_last;
  logic                  out_sat;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(
    .N_POINTS           (N),
    .DATA_WIDTH         (DW),
    .VIRTUAL_DATA_WIDTH (VDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  typedef struct {
    int re;
    int im;
  } samp_t;

  samp_t in_q[$];
  int cap_re[$];
  int cap_im[$];
  int cap_idx[$];
  int cap_last[$];
  int cap_sat[$];
  int cap_cyc[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  int first_valid_cyc = -1;
  int last_wr_cyc = -1;

  // Natural bin n holds the sample that arrived at position br[n].
  int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic drive();
    in_valid = (in_q.size() > 0);
    if (in_q.size() > 0) begin
      in_real = VDW'(in_q[0].re);
      in_imag = VDW'(in_q[0].im);
    end else begin
      in_real = '0;
      in_imag = '0;
    end
  endtask

  // One clock: observe handshakes at the negedge, then advance and re-drive.
  task automatic cycle();
    logic w_acc;
    @(negedge clk);
    w_acc = in_valid && in_ready;
    if (!rst && out_valid && out_ready) begin
      cap_re.push_back(int'(out_real));
      cap_im.push_back(int'(out_imag));
      cap_idx.push_back(int'(out_index));
      cap_last.push_back(int'(out_last));
      cap_sat.push_back(int'(out_sat));
      cap_cyc.push_back(cyc);
      $display("out  cyc=%0d idx=%0d re=%0d im=%0d last=%0d sat=%0d",
               cyc, out_index, out_real, out_imag, out_last, out_sat);
    end
    if (!rst && w_acc) begin
      acc_cnt++;
      last_wr_cyc = cyc;
      $display("in   cyc=%0d re=%0d im=%0d", cyc, in_real, in_imag);
    end
    if (!rst && enable && in_valid && !in_ready) stall_cnt++;
    if (!rst && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    @(posedge clk);
    #1;
    if (w_acc) void'(in_q.pop_front());
    drive();
    cyc++;
  endtask

  task automatic clear_stats();
    cap_re.delete();
    cap_im.delete();
    cap_idx.delete();
    cap_last.delete();
    cap_sat.delete();
    cap_cyc.delete();
    acc_cnt = 0;
    stall_cnt = 0;
    first_valid_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic wait_outputs(input int want, input int budget, input string name);
    int b;
    b = budget;
    while (cap_re.size() < want && b > 0) begin
      cycle();
      b--;
    end
    checks++;
    if (cap_re.size() < want) begin
      $display("FAIL %s_timeout got=%0d outputs want=%0d", name, cap_re.size(), want);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; out_ready = 1'b0;
    drive();
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%0b want=0", out_valid); errors++; end
    checks++; if (out_real !== 16'sd0) begin $display("FAIL reset_out_real got=%0d want=0", out_real); errors++; end
    checks++; if (out_imag !== 16'sd0) begin $display("FAIL reset_out_imag got=%0d want=0", out_imag); errors++; end
    checks++; if (out_index !== 3'd0) begin $display("FAIL reset_out_index got=%0d want=0", out_index); errors++; end
    checks++; if (out_last !== 1'b0) begin $display("FAIL reset_out_last got=%0b want=0", out_last); errors++; end
    checks++; if (out_sat !== 1'b0) begin $display("FAIL reset_out_sat got=%0b want=0", out_sat); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%0b want=1", in_ready); errors++; end
  endtask

  task automatic test_ordering();
    clear_stats();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) in_q.push_back('{re: k, im: -k});
    drive();
    wait_outputs(8, 40, "ordering");
    for (int n = 0; n < cap_re.size() && n < N; n++) begin
      checks++;
      if (cap_re[n] !== br[n] || cap_im[n] !== -br[n] || cap_idx[n] !== n ||
          cap_last[n] !== ((n == N - 1) ? 1 : 0)) begin
        $display("FAIL ordering_out%0d got re=%0d im=%0d idx=%0d last=%0d want re=%0d im=%0d idx=%0d last=%0d",
                 n, cap_re[n], cap_im[n], cap_idx[n], cap_last[n], br[n], -br[n], n, (n == N - 1) ? 1 : 0);
        errors++;
      end
    end
    // Loaded at the posedge after the frame turns FULL.
    checks++;
    if (first_valid_cyc - last_wr_cyc !== 2) begin
      $display("FAIL ordering_latency got=%0d want=2 (cycles from last write to first valid)",
               first_valid_cyc - last_wr_cyc);
      errors++;
    end
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    clear_stats();
    out_ready = 1'b1;
    for (int i = 0; i < 4 * N; i++) in_q.push_back('{re: i, im: -i});
    drive();
    wait_outputs(32, 120, "b2b");
    for (int j = 0; j < cap_re.size() && j < 32; j++) begin
      checks++;
      if (cap_re[j] !== (j / 8) * 8 + br[j % 8] || cap_im[j] !== -((j / 8) * 8 + br[j % 8]) ||
          cap_idx[j] !== j % 8) begin
        $display("FAIL b2b_out%0d got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                 j, cap_re[j], cap_im[j], cap_idx[j], (j / 8) * 8 + br[j % 8],
                 -((j / 8) * 8 + br[j % 8]), j % 8);
        errors++;
      end
      if (j > 0) begin
        checks++;
        if (cap_cyc[j] - cap_cyc[j-1] !== 1) begin
          $display("FAIL b2b_gap%0d got=%0d want=1", j, cap_cyc[j] - cap_cyc[j-1]);
          errors++;
        end
      end
    end
    checks++;
    if (stall_cnt !== 0) begin
      $display("FAIL b2b_in_ready_drops got=%0d want=0", stall_cnt);
      errors++;
    end
    repeat (3) cycle();
  endtask

  task automatic test_backpressure();
    int b;
    clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) in_q.push_back('{re: 100 + i, im: -(100 + i)});
    drive();
    b = 40;
    while (!out_valid && b > 0) begin cycle(); b--; end
    checks++;
    if (out_valid !== 1'b1) begin $display("FAIL bp_first_valid got=%0b want=1", out_valid); errors++; end
    for (int c = 0; c < 20; c++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'd0 || out_real !== 16'sd100 || out_imag !== -16'sd100) begin
        $display("FAIL bp_hold%0d got valid=%0b idx=%0d re=%0d im=%0d want valid=1 idx=0 re=100 im=-100",
                 c, out_valid, out_index, out_real, out_imag);
        errors++;
      end
    end
    checks++;
    if (acc_cnt !== 16 || in_ready !== 1'b0) begin
      $display("FAIL bp_in_blocked got writes=%0d in_ready=%0b want writes=16 in_ready=0", acc_cnt, in_ready);
      errors++;
    end
    out_ready = 1'b1;
    wait_outputs(16, 60, "bp");
    for (int j = 0; j < cap_re.size() && j < 16; j++) begin
      checks++;
      if (cap_re[j] !== 100 + (j / 8) * 8 + br[j % 8] || cap_idx[j] !== j % 8) begin
        $display("FAIL bp_out%0d got re=%0d idx=%0d want re=%0d idx=%0d",
                 j, cap_re[j], cap_idx[j], 100 + (j / 8) * 8 + br[j % 8], j % 8);
        errors++;
      end
    end
    repeat (3) cycle();
  endtask

  task automatic test_saturation();
    int in_re[8] = '{131071, 11, 40000, 13, 32767, 15, -32769, 17};
    int in_im[8] = '{-131072, -11, 5, -13, -32768, -15, 0, -17};
    int ex_re[8] = '{32767, 32767, 32767, -32768, 11, 15, 13, 17};
    int ex_im[8] = '{-32768, -32768, 5, 0, -11, -15, -13, -17};
    int ex_sat[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    clear_stats();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) in_q.push_back('{re: in_re[k], im: in_im[k]});
    drive();
    wait_outputs(8, 40, "sat");
    for (int n = 0; n < cap_re.size() && n < N; n++) begin
      checks++;
      if (cap_re[n] !== ex_re[n] || cap_im[n] !== ex_im[n] || cap_sat[n] !== ex_sat[n]) begin
        $display("FAIL sat_out%0d got re=%0d im=%0d sat=%0d want re=%0d im=%0d sat=%0d",
                 n, cap_re[n], cap_im[n], cap_sat[n], ex_re[n], ex_im[n], ex_sat[n]);
        errors++;
      end
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid();
    int b;
    int bad;
    clear_stats();
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) in_q.push_back('{re: 200 + i, im: -(200 + i)});
    drive();
    b = 60;
    while (acc_cnt < 13 && b > 0) begin cycle(); b--; end
    checks++;
    if (acc_cnt !== 13) begin $display("FAIL rstmid_writes got=%0d want=13", acc_cnt); errors++; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rstmid_after got valid=%0b in_ready=%0b want valid=0 in_ready=1", out_valid, in_ready);
      errors++;
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin $display("FAIL rstmid_idle_valid got=%0d want=0 cycles with valid", bad); errors++; end
    clear_stats();
    for (int k = 0; k < N; k++) in_q.push_back('{re: 300 + k, im: -(300 + k)});
    drive();
    wait_outputs(8, 40, "rstmid");
    for (int n = 0; n < cap_re.size() && n < N; n++) begin
      checks++;
      if (cap_re[n] !== 300 + br[n] || cap_idx[n] !== n) begin
        $display("FAIL rstmid_out%0d got re=%0d idx=%0d want re=%0d idx=%0d",
                 n, cap_re[n], cap_idx[n], 300 + br[n], n);
        errors++;
      end
    end
    repeat (3) cycle();
  endtask

  task automatic test_enable();
    clear_stats();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) in_q.push_back('{re: 400 + k, im: -(400 + k)});
    drive();
    wait_outputs(3, 40, "enable_pre");
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        $display("FAIL enable_gate%0d got valid=%0b in_ready=%0b want valid=0 in_ready=0",
                 c, out_valid, in_ready);
        errors++;
      end
      cycle();
    end
    enable = 1'b1;
    wait_outputs(8, 40, "enable");
    repeat (5) cycle();
    checks++;
    if (cap_re.size() !== 8) begin $display("FAIL enable_count got=%0d want=8", cap_re.size()); errors++; end
    for (int n = 0; n < cap_re.size() && n < N; n++) begin
      checks++;
      if (cap_re[n] !== 400 + br[n] || cap_idx[n] !== n) begin
        $display("FAIL enable_out%0d got re=%0d idx=%0d want re=%0d idx=%0d",
                 n, cap_re[n], cap_idx[n], 400 + br[n], n);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
